serial_frame_deser: RTL and testbench

- Receive-side deserializer downstream of the three-flop serial synchronizer on the board serial input.
- Decodes UART-style frames carrying a 16-bit sample plus a 4-bit tag.
- Presents each frame as a one-cycle parallel word to the System Generator datapath: data_in, data_in1, and data_in3 as the strobe.
- Flags and counts malformed frames for PS readback.

---
 rtl/serial_frame_deser.sv | 189 ++++++++++++++++++
 tb/tb_serial_frame_deser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// serial_frame_deser
// Receive-side UART-style deserializer. Each frame is start(0), 20 payload
// bits LSB first (16-bit sample then 4-bit tag), even parity over the
// payload, and stop(1). A good frame is presented as a one-cycle parallel
// word. Malformed frames raise a one-cycle error strobe and bump a
// saturating error counter.
module serial_frame_deser #(
   parameter int CLKS_PER_BIT = 16,
   parameter int ERR_CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ser_in,
   output logic [15:0]          data_out,
   output logic [3:0]           tag_out,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   // Half-bit reload centres sampling in the middle of each bit time.
   localparam logic [CNT_W-1:0]     HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]     FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;
   localparam logic [4:0]           LAST_BIT    = 5'd19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRK
   } state_t;

   state_t                 state_reg,      state_next;
   logic [CNT_W-1:0]       cnt_reg,        cnt_next;
   logic [4:0]             bit_idx_reg,    bit_idx_next;
   logic [19:0]            shreg_reg,      shreg_next;
   logic                   par_ok_reg,     par_ok_next;
   logic [15:0]            data_reg,       data_next;
   logic [3:0]             tag_reg,        tag_next;
   logic                   valid_reg,      valid_next;
   logic                   parity_err_reg, parity_err_next;
   logic                   frame_err_reg,  frame_err_next;
   logic [ERR_CNT_W-1:0]   err_cnt_reg,    err_cnt_next;

   logic                   tick;
   logic                   err_event;

   assign tick = (cnt_reg == '0);

   // State and datapath registers; reset returns to IDLE and clears outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         shreg_reg      <= '0;
         par_ok_reg     <= 1'b0;
         data_reg       <= '0;
         tag_reg        <= '0;
         valid_reg      <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         err_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_idx_reg    <= bit_idx_next;
         shreg_reg      <= shreg_next;
         par_ok_reg     <= par_ok_next;
         data_reg       <= data_next;
         tag_reg        <= tag_next;
         valid_reg      <= valid_next;
         parity_err_reg <= parity_err_next;
         frame_err_reg  <= frame_err_next;
         err_cnt_reg    <= err_cnt_next;
      end
   end

   // Next-state, bit timing, payload capture and strobe generation.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      bit_idx_next    = bit_idx_reg;
      shreg_next      = shreg_reg;
      par_ok_next     = par_ok_reg;
      data_next       = data_reg;
      tag_next        = tag_reg;
      valid_next      = 1'b0;
      parity_err_next = 1'b0;
      frame_err_next  = 1'b0;
      err_event       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!ser_in) begin
               state_next = ST_START;
               cnt_next   = HALF_RELOAD;
            end
         end
         ST_START: begin
            if (tick) begin
               if (ser_in) begin
                  // Line went back high before mid-start: treat as noise.
                  state_next = ST_IDLE;
               end else begin
                  state_next   = ST_DATA;
                  cnt_next     = FULL_RELOAD;
                  bit_idx_next = '0;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_next[bit_idx_reg] = ser_in;
               cnt_next                = FULL_RELOAD;
               if (bit_idx_reg == LAST_BIT) begin
                  state_next = ST_PARITY;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_PARITY: begin
            if (tick) begin
               par_ok_next = ((^shreg_reg) ^ ser_in) == 1'b0;
               cnt_next    = FULL_RELOAD;
               state_next  = ST_STOP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (ser_in) begin
                  state_next = ST_IDLE;
                  if (par_ok_reg) begin
                     data_next  = shreg_reg[15:0];
                     tag_next   = shreg_reg[19:16];
                     valid_next = 1'b1;
                  end else begin
                     parity_err_next = 1'b1;
                     err_event       = 1'b1;
                  end
               end else begin
                  // Stop bit low: framing error wins regardless of parity.
                  frame_err_next = 1'b1;
                  err_event      = 1'b1;
                  state_next     = ST_BRK;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_BRK: begin
            // Hold off start detection until the line has recovered high.
            if (ser_in) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      err_cnt_next = err_cnt_reg;
      if (err_event && (err_cnt_reg != ERR_MAX)) begin
         err_cnt_next = err_cnt_reg + 1'b1;
      end
   end

   assign data_out   = data_reg;
   assign tag_out    = tag_reg;
   assign valid      = valid_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign err_count  = err_cnt_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_deser.sv
// Bench for serial_frame_deser: directed frames drive the serial line while a
// scoreboard queue holds the expected strobe, payload, error count and
// arrival cycle. A monitor on the falling edge pops and compares whenever a
// strobe appears, and flags strobes that are late or unexpected.
`timescale 1ns/1ps
module tb_serial_frame_deser;

   localparam int CPB       = 16;
   localparam int ERR_W     = 2;
   localparam int LATENCY   = CPB / 2 + 22 * CPB + 1;  // 361 clk

   localparam int K_VALID  = 0;
   localparam int K_PARITY = 1;
   localparam int K_FRAME  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ser_in = 1'b1;
   logic [15:0]       data_out;
   logic [3:0]        tag_out;
   logic              valid;
   logic              parity_err;
   logic              frame_err;
   logic [ERR_W-1:0]  err_count;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          kind;
      logic [15:0] d;
      logic [3:0]  t;
      logic [1:0]  e;
      int          at;
   } exp_t;

   exp_t sb[$];

   // Last good payload the DUT is expected to be holding.
   logic [15:0] model_d = '0;
   logic [3:0]  model_t = '0;

   serial_frame_deser #(
      .CLKS_PER_BIT (CPB),
      .ERR_CNT_W    (ERR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ser_in     (ser_in),
      .data_out   (data_out),
      .tag_out    (tag_out),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .err_count  (err_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: compare each strobe against the head of the scoreboard.
   exp_t        m_e;
   logic [2:0]  m_strb;
   logic [2:0]  m_want;
   always @(negedge clk) begin
      if (rst_n) begin
         m_strb = {frame_err, parity_err, valid};
         if (m_strb != 3'b000) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got strobes %b expected none (cycle %0d)", m_strb, cyc);
            end else begin
               m_e    = sb.pop_front();
               m_want = 3'b001 << m_e.kind;
               check("strobe_kind", 32'(m_strb), 32'(m_want));
               check("data_out",    32'(data_out), 32'(m_e.d));
               check("tag_out",     32'(tag_out), 32'(m_e.t));
               check("err_count",   32'(err_count), 32'(m_e.e));
               checks++;
               if (cyc < m_e.at - 1 || cyc > m_e.at + 1) begin
                  errors++;
                  $display("FAIL strobe_latency: got cycle %0d expected %0d +-1", cyc, m_e.at);
               end
               $display("strobe kind=%0d data=0x%04h tag=0x%0h err=%0d cycle=%0d",
                        m_e.kind, data_out, tag_out, err_count, cyc);
            end
         end else if (sb.size() > 0 && cyc > sb[0].at + 1) begin
            m_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: got none expected kind %0d by cycle %0d", m_e.kind, m_e.at + 1);
         end
      end
   end

   task automatic send_bit(input logic b);
      ser_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Sends one frame starting at a falling edge and queues its expected outcome.
   task automatic send_frame(input logic [15:0] d, input logic [3:0] t,
                             input bit flip_par, input bit stop, input logic [1:0] exp_err);
      logic [19:0] p;
      exp_t        e;
      p = {t, d};
      if (!stop) begin
         e.kind = K_FRAME;
      end else if (flip_par) begin
         e.kind = K_PARITY;
      end else begin
         e.kind  = K_VALID;
         model_d = d;
         model_t = t;
      end
      e.d  = model_d;
      e.t  = model_t;
      e.e  = exp_err;
      e.at = cyc + LATENCY;
      sb.push_back(e);
      $display("send data=0x%04h tag=0x%0h flip_par=%0d stop=%0d cycle=%0d", d, t, flip_par, stop, cyc);
      send_bit(1'b0);
      for (int i = 0; i < 20; i++) send_bit(p[i]);
      send_bit((^p) ^ flip_par);
      send_bit(stop);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      ser_in  = 1'b1;
      model_d = '0;
      model_t = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   int bad_busy;

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_data",   32'(data_out), 32'h0);
      check("rst_tag",    32'(tag_out), 32'h0);
      check("rst_valid",  32'(valid), 32'h0);
      check("rst_perr",   32'(parity_err), 32'h0);
      check("rst_ferr",   32'(frame_err), 32'h0);
      check("rst_errcnt", 32'(err_count), 32'h0);
      check("rst_busy",   32'(busy), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Good frame, then the same frame with bad parity.
      send_frame(16'hA5C3, 4'h9, 1'b0, 1'b1, 2'd0);
      repeat (20) @(negedge clk);
      send_frame(16'hA5C3, 4'h9, 1'b1, 1'b1, 2'd1);
      repeat (20) @(negedge clk);

      // Framing error with the line held low for 40 bit times.
      send_frame(16'h1111, 4'h2, 1'b0, 1'b0, 2'd2);
      bad_busy = 0;
      repeat (40 * CPB) begin
         @(negedge clk);
         if (!busy) bad_busy++;
      end
      check("break_busy_lost", 32'(bad_busy), 32'h0);
      ser_in = 1'b1;
      repeat (4) @(negedge clk);
      check("break_exit_idle", 32'(busy), 32'h0);
      send_frame(16'h0001, 4'h0, 1'b0, 1'b1, 2'd2);
      repeat (20) @(negedge clk);

      // Glitch shorter than half a bit on an idle line.
      ser_in = 1'b0;
      repeat (3) @(negedge clk);
      check("glitch_start_busy", 32'(busy), 32'h1);
      repeat (CPB / 2 - 2 - 3) @(negedge clk);
      ser_in = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_busy", 32'(busy), 32'h0);
      check("glitch_errcnt", 32'(err_count), 32'h2);
      check("glitch_data_hold", 32'(data_out), 32'h0001);

      // Three frames back to back with no idle time.
      send_frame(16'hFFFF, 4'hF, 1'b0, 1'b1, 2'd2);
      send_frame(16'h0000, 4'h0, 1'b0, 1'b1, 2'd2);
      send_frame(16'h1234, 4'h5, 1'b0, 1'b1, 2'd2);
      repeat (20) @(negedge clk);

      // Saturation of a 2-bit counter from a fresh reset.
      do_reset();
      check("rst2_errcnt", 32'(err_count), 32'h0);
      send_frame(16'h0F0F, 4'h3, 1'b1, 1'b1, 2'd1);
      send_frame(16'h0F0F, 4'h3, 1'b1, 1'b1, 2'd2);
      send_frame(16'h0F0F, 4'h3, 1'b1, 1'b1, 2'd3);
      send_frame(16'h0F0F, 4'h3, 1'b1, 1'b1, 2'd3);
      send_frame(16'h0F0F, 4'h3, 1'b1, 1'b1, 2'd3);
      send_frame(16'hBEEF, 4'hC, 1'b0, 1'b1, 2'd3);
      repeat (20) @(negedge clk);

      // Reset asserted in the middle of the DATA phase.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (5) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_data",   32'(data_out), 32'h0);
      check("midrst_tag",    32'(tag_out), 32'h0);
      check("midrst_valid",  32'(valid), 32'h0);
      check("midrst_errcnt", 32'(err_count), 32'h0);
      check("midrst_busy",   32'(busy), 32'h0);
      model_d = '0;
      model_t = '0;
      ser_in  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (500) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'h0);

      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
